// File: rtl/serial_echo_initiator.sv
// serial_echo_initiator
//   Self-test master for an asynchronous serial echo link. Sends NUM_WORDS
//   words (START_WORD, START_WORD+1, ...) one at a time on out_serial. After
//   each word it waits for the far end to echo the word back on in_serial.
//   It then compares the echo with the sent word and counts bad words.
// Ports
//   in_clk / in_rst      : main clock, asynchronous active-low reset
//   in_start             : starts a run; only looked at while idle
//   out_serial           : transmit line, idle high
//   in_serial            : echo line, asynchronous to in_clk
//   out_busy / out_done  : run in progress / one-cycle end-of-run pulse
//   out_pass             : last run finished with zero errors
//   out_err_count        : saturating count of bad words (timeout, framing, data)
//   out_last_tx/_rx      : last word sent / last word received (0 on timeout)
module serial_echo_initiator #(
  parameter int              BITS          = 8,
  parameter int              MAIN_CLK_HZ   = 27_000_000,
  parameter int              SERIAL_CLK_HZ = 115_200,
  parameter int              NUM_WORDS     = 16,
  parameter logic [BITS-1:0] START_WORD    = 8'h41,
  parameter int              TIMEOUT_BITS  = 32
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_start,
  output logic            out_serial,
  input  logic            in_serial,
  output logic            out_busy,
  output logic            out_done,
  output logic            out_pass,
  output logic [7:0]      out_err_count,
  output logic [BITS-1:0] out_last_tx,
  output logic [BITS-1:0] out_last_rx
);

  localparam int              BIT_CYC   = MAIN_CLK_HZ / SERIAL_CLK_HZ;
  localparam int              BW        = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [31:0]     CYC_LAST  = 32'(BIT_CYC - 1);
  localparam logic [31:0]     HALF_LAST = 32'(BIT_CYC / 2 - 1);
  localparam logic [31:0]     TO_LAST   = 32'(TIMEOUT_BITS * BIT_CYC - 1);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(BITS - 1);
  localparam logic [7:0]      IDX_LAST  = 8'(NUM_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_TX_START, S_TX_DATA, S_TX_STOP, S_RX_WAIT,
    S_RX_HALF, S_RX_DATA, S_RX_STOP, S_COMPARE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;        // bit timer, counts down to 0
  logic [31:0]     to_q, to_d;          // echo timeout, counts down to 0
  logic [BW-1:0]   bit_idx_q, bit_idx_d;
  logic [7:0]      idx_q, idx_d;        // word index within the run
  logic [BITS-1:0] tx_sh_q, tx_sh_d;
  logic [BITS-1:0] rx_sh_q, rx_sh_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [7:0]      err_q, err_d;
  logic [BITS-1:0] last_tx_q, last_tx_d;
  logic [BITS-1:0] last_rx_q, last_rx_d;
  logic            tout_q, tout_d;
  logic            ferr_q, ferr_d;
  logic            sync1_q, sync2_q, sync3_q;

  logic            cnt_zero, rx_fall, word_bad;
  logic [31:0]     cnt_dec;
  logic [7:0]      err_inc;

  assign cnt_zero = (cnt_q == 32'd0);
  assign cnt_dec  = cnt_q - 32'd1;
  // sync3 only remembers the previous synchronised value, for edge detection
  assign rx_fall  = sync3_q & ~sync2_q;
  assign word_bad = tout_q | ferr_q | (last_rx_q != last_tx_q);
  assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    bit_idx_d = bit_idx_q;
    idx_d     = idx_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    last_tx_d = last_tx_q;
    last_rx_d = last_rx_q;
    tout_d    = tout_q;
    ferr_d    = ferr_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (in_start) begin
          err_d     = 8'd0;
          pass_d    = 1'b0;
          idx_d     = 8'd0;
          busy_d    = 1'b1;
          last_tx_d = START_WORD;
          tx_sh_d   = START_WORD;
          tx_d      = 1'b0;
          cnt_d     = CYC_LAST;
          state_d   = S_TX_START;
        end
      end
      S_TX_START: begin
        if (cnt_zero) begin
          tx_d      = tx_sh_q[0];
          tx_sh_d   = tx_sh_q >> 1;
          bit_idx_d = '0;
          cnt_d     = CYC_LAST;
          state_d   = S_TX_DATA;
        end else cnt_d = cnt_dec;
      end
      S_TX_DATA: begin
        if (cnt_zero) begin
          cnt_d = CYC_LAST;
          if (bit_idx_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = S_TX_STOP;
          end else begin
            tx_d      = tx_sh_q[0];
            tx_sh_d   = tx_sh_q >> 1;
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else cnt_d = cnt_dec;
      end
      S_TX_STOP: begin
        if (cnt_zero) begin
          to_d    = TO_LAST;
          state_d = S_RX_WAIT;
        end else cnt_d = cnt_dec;
      end
      S_RX_WAIT: begin
        if (to_q == 32'd0) begin
          tout_d    = 1'b1;
          last_rx_d = '0;
          state_d   = S_COMPARE;
        end else begin
          to_d = to_q - 32'd1;
          if (rx_fall) begin
            cnt_d   = HALF_LAST;
            state_d = S_RX_HALF;
          end
        end
      end
      S_RX_HALF: begin
        // timeout keeps running so a noisy line cannot stall the run forever
        if (to_q != 32'd0) to_d = to_q - 32'd1;
        if (cnt_zero) begin
          if (!sync2_q) begin
            cnt_d     = CYC_LAST;
            bit_idx_d = '0;
            state_d   = S_RX_DATA;
          end else state_d = S_RX_WAIT;   // glitch, not a start bit
        end else cnt_d = cnt_dec;
      end
      S_RX_DATA: begin
        if (cnt_zero) begin
          rx_sh_d = {sync2_q, rx_sh_q[BITS-1:1]};
          cnt_d   = CYC_LAST;
          if (bit_idx_q == BIT_LAST) state_d = S_RX_STOP;
          else bit_idx_d = bit_idx_q + BW'(1);
        end else cnt_d = cnt_dec;
      end
      S_RX_STOP: begin
        if (cnt_zero) begin
          ferr_d    = ~sync2_q;
          last_rx_d = rx_sh_q;
          state_d   = S_COMPARE;
        end else cnt_d = cnt_dec;
      end
      S_COMPARE: begin
        if (word_bad) err_d = err_inc;
        tout_d = 1'b0;
        ferr_d = 1'b0;
        if (idx_q == IDX_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
          state_d = S_DONE;
        end else begin
          idx_d     = idx_q + 8'd1;
          last_tx_d = last_tx_q + BITS'(1);
          tx_sh_d   = last_tx_q + BITS'(1);
          tx_d      = 1'b0;
          cnt_d     = CYC_LAST;
          state_d   = S_TX_START;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      to_q      <= 32'd0;
      bit_idx_q <= '0;
      idx_q     <= 8'd0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 8'd0;
      last_tx_q <= '0;
      last_rx_q <= '0;
      tout_q    <= 1'b0;
      ferr_q    <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      sync3_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      bit_idx_q <= bit_idx_d;
      idx_q     <= idx_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      last_tx_q <= last_tx_d;
      last_rx_q <= last_rx_d;
      tout_q    <= tout_d;
      ferr_q    <= ferr_d;
      sync1_q   <= in_serial;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
    end
  end

  assign out_serial    = tx_q;
  assign out_busy      = busy_q;
  assign out_done      = done_q;
  assign out_pass      = pass_q;
  assign out_err_count = err_q;
  assign out_last_tx   = last_tx_q;
  assign out_last_rx   = last_rx_q;

endmodule

// File: tb/tb_serial_echo_initiator.sv
// Directed bench for serial_echo_initiator. Instance A runs with a 16-cycle
// bit period and 4 words per run. A behavioural far-end responder captures
// each frame from out_serial and sends it back, optionally corrupted.
// Instance B runs 255 words with no echo at all, which drives the error
// count to saturation.
module tb_serial_echo_initiator;
  localparam int BC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, b_start, echo_line, glitch_line;
  logic b_rx = 1'b1;
  logic a_rx;
  logic a_tx, a_busy, a_done, a_pass;
  logic [7:0] a_err, a_ltx, a_lrx;
  logic b_tx, b_busy, b_done, b_pass;
  logic [7:0] b_err, b_ltx, b_lrx;
  assign a_rx = echo_line & glitch_line;

  serial_echo_initiator #(.BITS(8), .MAIN_CLK_HZ(1600), .SERIAL_CLK_HZ(100),
    .NUM_WORDS(4), .START_WORD(8'h41), .TIMEOUT_BITS(32)) dut_a (
    .in_clk(clk), .in_rst(rst_n), .in_start(start), .out_serial(a_tx),
    .in_serial(a_rx), .out_busy(a_busy), .out_done(a_done), .out_pass(a_pass),
    .out_err_count(a_err), .out_last_tx(a_ltx), .out_last_rx(a_lrx));

  serial_echo_initiator #(.BITS(8), .MAIN_CLK_HZ(400), .SERIAL_CLK_HZ(100),
    .NUM_WORDS(255), .START_WORD(8'h41), .TIMEOUT_BITS(2)) dut_b (
    .in_clk(clk), .in_rst(rst_n), .in_start(b_start), .out_serial(b_tx),
    .in_serial(b_rx), .out_busy(b_busy), .out_done(b_done), .out_pass(b_pass),
    .out_err_count(b_err), .out_last_tx(b_ltx), .out_last_rx(b_lrx));

  int n_vec = 0, n_err = 0;
  logic       echo_en, echo_flip;
  logic [7:0] bad_stop_word;
  int         echo_gap;
  logic [7:0] cap_mem [512];
  int         cap_wr = 0;
  int         done_cnt = 0;

  always @(negedge clk) if (a_done === 1'b1) done_cnt <= done_cnt + 1;

  // far end, receive half: sample each bit of a frame mid-bit
  initial begin : capture
    logic [7:0] w;
    forever begin
      @(negedge a_tx);
      repeat (BC/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BC) @(negedge clk);
        w[i] = a_tx;
      end
      repeat (BC) @(negedge clk);
      cap_mem[cap_wr % 512] = w;
      cap_wr = cap_wr + 1;
    end
  end

  // far end, transmit half: echo each captured word
  initial begin : sender
    int rd;
    logic [7:0] w, wo;
    rd = 0;
    echo_line = 1'b1;
    forever begin
      @(negedge clk);
      if (rd != cap_wr) begin
        wo = cap_mem[rd % 512];
        rd = rd + 1;
        w = wo;
        if (echo_en) begin
          if (echo_flip) w[0] = ~w[0];
          repeat (echo_gap) @(negedge clk);
          echo_line = 1'b0;
          repeat (BC) @(negedge clk);
          for (int i = 0; i < 8; i++) begin
            echo_line = w[i];
            repeat (BC) @(negedge clk);
          end
          echo_line = (wo == bad_stop_word) ? 1'b0 : 1'b1;
          repeat (BC) @(negedge clk);
          echo_line = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    while (a_done !== 1'b1 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 32'(a_done), 1);
  endtask

  initial begin : main
    int cyc, base, n, d0;
    rst_n = 1'b0; start = 1'b0; b_start = 1'b0; glitch_line = 1'b1;
    echo_en = 1'b1; echo_flip = 1'b0; bad_stop_word = 8'h00; echo_gap = BC;
    cycles(3);
    chk("rst_serial", 32'(a_tx), 1);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_pass", 32'(a_pass), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_last_tx", 32'(a_ltx), 0);
    chk("rst_last_rx", 32'(a_lrx), 0);
    rst_n = 1'b1;
    cycles(2);

    // clean echo
    base = cap_wr;
    pulse_start();
    chk("first_start_bit", 32'(a_tx), 0);
    chk("busy_at_start", 32'(a_busy), 1);
    n = 0;
    while (a_tx === 1'b0 && n < 100) begin n++; @(negedge clk); end
    chk("start_bit_len", n, BC);
    d0 = done_cnt;
    wait_done(4000, cyc);
    chk("echo_pass", 32'(a_pass), 1);
    chk("echo_err", 32'(a_err), 0);
    chk("echo_busy_done", 32'(a_busy), 0);
    chk("echo_last_rx", 32'(a_lrx), 32'h44);
    chk("echo_last_tx", 32'(a_ltx), 32'h44);
    cycles(20);
    chk("echo_done_pulses", done_cnt - d0, 1);
    for (int k = 0; k < 4; k++) chk("tx_word", 32'(cap_mem[(base + k) % 512]), 32'h41 + k);

    // bit 0 flipped on every echo, start pulses ignored mid-run
    echo_flip = 1'b1;
    d0 = done_cnt;
    pulse_start();
    repeat (3) begin
      cycles(300);
      chk("busy_mid_run", 32'(a_busy), 1);
      start = 1'b1; @(negedge clk); start = 1'b0;
    end
    wait_done(4000, cyc);
    chk("flip_err", 32'(a_err), 4);
    chk("flip_pass", 32'(a_pass), 0);
    chk("flip_last_rx", 32'(a_lrx), 32'h45);
    chk("flip_last_tx", 32'(a_ltx), 32'h44);
    cycles(20);
    chk("flip_done_pulses", done_cnt - d0, 1);
    chk("flip_err_hold", 32'(a_err), 4);
    echo_flip = 1'b0;

    // no echo: every word times out
    echo_en = 1'b0;
    pulse_start();
    wait_done(4000, cyc);
    chk("tout_err", 32'(a_err), 4);
    chk("tout_last_rx", 32'(a_lrx), 0);
    chk("tout_pass", 32'(a_pass), 0);
    chk("tout_run_len", 32'(cyc >= 4*42*BC && cyc <= 4*42*BC + 24), 1);
    echo_en = 1'b1;

    // stop bit low on the echo of 0x43 only
    bad_stop_word = 8'h43;
    pulse_start();
    wait_done(4000, cyc);
    chk("ferr_err", 32'(a_err), 1);
    chk("ferr_pass", 32'(a_pass), 0);
    chk("ferr_last_rx", 32'(a_lrx), 32'h44);
    bad_stop_word = 8'h00;

    // short low glitch while waiting for the first echo
    echo_gap = 5*BC;
    pulse_start();
    cycles(10*BC + 1);
    glitch_line = 1'b0;
    cycles(4);
    glitch_line = 1'b1;
    wait_done(4000, cyc);
    chk("glitch_err", 32'(a_err), 0);
    chk("glitch_pass", 32'(a_pass), 1);
    chk("glitch_last_rx", 32'(a_lrx), 32'h44);
    echo_gap = BC;

    // reset during bit 0 of word 1 (0x42, bit 0 low)
    echo_en = 1'b0;
    pulse_start();
    cycles(42*BC + BC + 6);
    chk("pre_rst_serial_low", 32'(a_tx), 0);
    chk("pre_rst_err", 32'(a_err), 1);
    chk("pre_rst_last_tx", 32'(a_ltx), 32'h42);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_serial", 32'(a_tx), 1);
    chk("arst_busy", 32'(a_busy), 0);
    chk("arst_err", 32'(a_err), 0);
    chk("arst_last_tx", 32'(a_ltx), 0);
    chk("arst_last_rx", 32'(a_lrx), 0);
    chk("arst_pass", 32'(a_pass), 0);
    chk("arst_done", 32'(a_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(200);
    echo_en = 1'b1;
    base = cap_wr;
    pulse_start();
    chk("restart_last_tx", 32'(a_ltx), 32'h41);
    wait_done(4000, cyc);
    chk("restart_pass", 32'(a_pass), 1);
    chk("restart_last_rx", 32'(a_lrx), 32'h44);
    chk("restart_word0", 32'(cap_mem[base % 512]), 32'h41);

    // 255 words, never echoed: error count saturates
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    cyc = 0;
    while (b_done !== 1'b1 && cyc < 20000) begin @(negedge clk); cyc++; end
    chk("sat_done_seen", 32'(b_done), 1);
    chk("sat_err", 32'(b_err), 255);
    chk("sat_pass", 32'(b_pass), 0);
    chk("sat_last_tx", 32'(b_ltx), 32'h3F);
    chk("sat_last_rx", 32'(b_lrx), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_echo_initiator.md
# serial_echo_initiator

Initiating end of the asynchronous serial echo link: sends a deterministic sequence of words on its own transmit line, waits for each word to be echoed back by the far-end echo responder, compares the result and counts errors. Serves as an on-board self-test master: wire it to the UART pins of a second board running the echo responder, or loop the pins back to self-test. It contains its own bit-timed transmitter and receiver, so the link under test is exercised independently of the existing serial modules.

## Interface
- BITS, 8: data bits per word
- MAIN_CLK_HZ, 27_000_000: in_clk frequency
- SERIAL_CLK_HZ, 115_200: baud rate
- NUM_WORDS, 16: words per test run (1..255)
- START_WORD, 8'h41: first pattern word; word k = START_WORD + k, mod 2^BITS
- TIMEOUT_BITS, 32: bit periods to wait for an echo start bit

Ports:
- in_clk  in  1  main clock
- in_rst  in  1  asynchronous, active-low reset
- in_start  in  1  pulse or level; sampled only in Idle
- out_serial  out  1  transmit line, idle high
- in_serial  in  1  echo line (asynchronous; synchronised internally)
- out_busy  out  1  high from run start until Done
- out_done  out  1  one-cycle pulse at end of run
- out_pass  out  1  valid after out_done: err_count == 0
- out_err_count  out  8  saturating error count of the current or last run
- out_last_tx  out  BITS  last word transmitted
- out_last_rx  out  BITS  last word received; 0 on timeout

## Operation
- Bit period: BIT_CYC = MAIN_CLK_HZ / SERIAL_CLK_HZ (integer, truncated; 234 at defaults). One down-counter generates all bit timing.
- in_serial passes through a 2-flop synchroniser before use.
- FSM states: Idle, TxStart, TxData, TxStop, RxWait, RxHalf, RxData, RxStop, Compare, Done.
- Idle: out_serial=1; if in_start=1, clear err_count and word index, set out_busy, go to TxStart.
- TxStart: out_serial=0 for BIT_CYC cycles. TxData: BITS bits, LSB first, BIT_CYC each. TxStop: out_serial=1 for BIT_CYC cycles, then go to RxWait with the timeout counter loaded with TIMEOUT_BITS*BIT_CYC.
- RxWait: a falling edge on the synchronised line goes to RxHalf. If the timeout expires first, record a timeout error, set out_last_rx=0 and go to Compare.
- RxHalf: wait BIT_CYC/2 cycles; line still low goes to RxData, line high (glitch) returns to RxWait. The timeout keeps counting.
- RxData: sample at each full BIT_CYC, LSB first, shift into the rx register. RxStop: sample after BIT_CYC; a low sample is a framing error.
- Compare (1 cycle): increment err_count (saturating at 255) on timeout, framing error or rx word != tx word. Then, if more words remain, go to TxStart with index+1; otherwise go to Done.
- Done (1 cycle): out_done=1, out_pass=(err_count==0), out_busy=0, then go to Idle. out_pass and out_err_count hold until the next run starts.
- in_start while busy is ignored.

## Timing
- Reset (in_rst=0, asynchronous): state Idle, out_serial=1, out_busy=0, out_done=0, out_pass=0, out_err_count=0, out_last_tx=0, out_last_rx=0, synchroniser flops=1. Reset mid-word aborts the word immediately; out_serial goes high without waiting for a clock.
- First start bit: out_serial falls 1 cycle after in_start is sampled in Idle.
- Transmit frame: exactly (BITS+2)*BIT_CYC cycles.
- Synchroniser delay: 2 cycles. Rx sampling occurs at BIT_CYC/2 + n*BIT_CYC (±1 cycle) after the synchronised edge.
- out_last_tx updates on entry to TxStart. out_last_rx updates on the RxStop to Compare transition.
- Run duration, loopback: NUM_WORDS*(2*(BITS+2)*BIT_CYC + small constant) cycles; the constant is at most 6 per word.

## Test plan
- Loopback (in_serial=out_serial), NUM_WORDS=4, START_WORD=8'h41, pulse in_start -> frames 0x41..0x44 observed LSB first at 234-cycle bit period; out_done pulses once; out_pass=1; out_err_count=0; out_last_rx=0x44.
- Echo model that flips bit 0 on every word, NUM_WORDS=4 -> out_err_count=4, out_pass=0, out_last_rx=0x45.
- in_serial held high, NUM_WORDS=3, TIMEOUT_BITS=32 -> each word times out 32*234 cycles after its stop bit; out_err_count=3, out_last_rx=0.
- Echo model with the stop bit low on word 2 only (data correct) -> out_err_count=1. A 50-cycle low glitch on in_serial during RxWait -> no error, and the run completes normally.
- Assert in_rst low during TxData of word 1 -> out_serial=1 with no clock edge needed; all outputs at reset values; a new in_start then begins again from START_WORD.
- Pulse in_start repeatedly during a run -> no effect; exactly one out_done per run. With NUM_WORDS=255 and an always-wrong echo -> out_err_count saturates at 255.
